// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-entry decode buffer, BOOT/RUN/HALT control.
// Optional halt-word detection is compiled in with `define FETCH_HALT_DETECT_EN.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pc_out,
  input  logic [15:0] inst_in,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [15:0] id_inst,
  output logic [7:0]  id_pc,
  output logic [7:0]  id_pc_plus1,
  output logic        halted
);

  localparam int unsigned PC_W   = 8;
  localparam int unsigned INST_W = 16;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                id_valid_q, id_valid_d;
  logic [INST_W-1:0]   id_inst_q, id_inst_d;
  logic [PC_W-1:0]     id_pc_q, id_pc_d;
  logic [PC_W-1:0]     id_pc_plus1_q, id_pc_plus1_d;
  logic [PC_W-1:0]     pc_plus1;
  logic                slot_free;
  logic                capture;
`ifdef FETCH_HALT_DETECT_EN
  logic                halted_q, halted_d;
`endif

  assign pc_plus1  = pc_q + PC_W'(1);
  // The buffer can take a new word when empty or when decode drains it this edge.
  assign slot_free = !id_valid_q || id_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus1_d = id_pc_plus1_q;
    capture       = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    halted_d      = halted_q;
`endif

    case (state_q)
      BOOT: begin
        state_d = RUN;
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          id_valid_d = 1'b0;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          id_valid_d = 1'b0;
        end else if (slot_free) begin
`ifdef FETCH_HALT_DETECT_EN
          // An all-zero word stops fetch without being handed to decode.
          if (inst_in == INST_W'(0)) begin
            id_valid_d = 1'b0;
            state_d    = HALT;
            halted_d   = 1'b1;
          end else begin
            capture = 1'b1;
          end
`else
          capture = 1'b1;
`endif
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (capture) begin
      id_valid_d    = 1'b1;
      id_inst_d     = inst_in;
      id_pc_d       = pc_q;
      id_pc_plus1_d = pc_plus1;
      pc_d          = pc_plus1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_inst_q     <= INST_W'(0);
      id_pc_q       <= PC_W'(0);
      id_pc_plus1_q <= PC_W'(0);
`ifdef FETCH_HALT_DETECT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus1_q <= id_pc_plus1_d;
`ifdef FETCH_HALT_DETECT_EN
      halted_q      <= halted_d;
`endif
    end
  end

  assign pc_out      = pc_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus1 = id_pc_plus1_q;
`ifdef FETCH_HALT_DETECT_EN
  assign halted      = halted_q;
`else
  assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirect, wrap, halt word, async reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  pc_out;
  logic [15:0] inst_in;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [15:0] id_inst;
  logic [7:0]  id_pc;
  logic [7:0]  id_pc_plus1;
  logic        halted;

  logic [15:0] mem [256];
  int n_vec;
  int n_err;

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .inst_in(inst_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc_plus1(id_pc_plus1), .halted(halted)
  );

  assign inst_in = mem[pc_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h55;
    id_ready = 1'b1;
    #1;
    n_vec++; if (pc_out !== 8'h00) begin n_err++; $display("FAIL rst_pc got %h want 00", pc_out); end
    n_vec++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", id_valid); end
    n_vec++; if (id_inst !== 16'h0000) begin n_err++; $display("FAIL rst_inst got %h want 0000", id_inst); end
    n_vec++; if (id_pc !== 8'h00 || id_pc_plus1 !== 8'h00) begin n_err++; $display("FAIL rst_idpc got %h/%h want 00/00", id_pc, id_pc_plus1); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted got %b want 0", halted); end
    step();
    n_vec++; if (pc_out !== 8'h00 || id_valid !== 1'b0) begin n_err++; $display("FAIL rst_hold got pc=%h v=%b want 00/0", pc_out, id_valid); end
    redirect_valid = 1'b0;
  endtask

  task automatic test_sequential();
    id_ready = 1'b1;
    release_reset();
    step();
    n_vec++; if (id_valid !== 1'b0 || pc_out !== 8'h00) begin n_err++; $display("FAIL boot got v=%b pc=%h want 0/00", id_valid, pc_out); end
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== 8'(k) || id_inst !== mem[k] || id_pc_plus1 !== 8'(k + 1)) begin
        n_err++;
        $display("FAIL seq%0d got v=%b pc=%h inst=%h p1=%h want 1/%h/%h/%h", k, id_valid, id_pc, id_inst, id_pc_plus1, 8'(k), mem[k], 8'(k + 1));
      end
    end
    n_vec++; if (pc_out !== 8'h04) begin n_err++; $display("FAIL seq_pcout got %h want 04", pc_out); end
  endtask

  task automatic test_stall();
    id_ready = 1'b1;
    release_reset();
    for (int k = 0; k < 4; k++) step();
    n_vec++; if (id_pc !== 8'h02) begin n_err++; $display("FAIL stall_pre got %h want 02", id_pc); end
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== 8'h02 || id_inst !== mem[2] || pc_out !== 8'h03) begin
        n_err++;
        $display("FAIL stall%0d got v=%b pc=%h inst=%h pcout=%h want 1/02/%h/03", k, id_valid, id_pc, id_inst, pc_out, mem[2]);
      end
    end
    id_ready = 1'b1;
    step();
    n_vec++; if (id_pc !== 8'h03 || id_inst !== mem[3] || id_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume got pc=%h inst=%h want 03/%h", id_pc, id_inst, mem[3]); end
    step();
    n_vec++; if (id_pc !== 8'h04 || id_inst !== mem[4]) begin n_err++; $display("FAIL stall_next got pc=%h want 04", id_pc); end
  endtask

  task automatic test_redirect_stall();
    id_ready = 1'b0;
    step();
    n_vec++; if (id_pc !== 8'h04 || id_valid !== 1'b1 || pc_out !== 8'h05) begin n_err++; $display("FAIL rd_stall got pc=%h pcout=%h want 04/05", id_pc, pc_out); end
    redirect_valid = 1'b1;
    redirect_pc = 8'h14;
    step();
    n_vec++; if (id_valid !== 1'b0 || pc_out !== 8'h14) begin n_err++; $display("FAIL rd_flush got v=%b pcout=%h want 0/14", id_valid, pc_out); end
    redirect_valid = 1'b0;
    step();
    n_vec++;
    if (id_valid !== 1'b1 || id_pc !== 8'h14 || id_inst !== mem[8'h14] || id_pc_plus1 !== 8'h15) begin
      n_err++;
      $display("FAIL rd_capture got v=%b pc=%h inst=%h p1=%h want 1/14/%h/15", id_valid, id_pc, id_inst, id_pc_plus1, mem[8'h14]);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [3];
    logic [7:0] exp_p1 [3];
    exp_pc = '{8'hFE, 8'hFF, 8'h00};
    exp_p1 = '{8'hFF, 8'h00, 8'h01};
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'hFE;
    step();
    n_vec++; if (id_valid !== 1'b0 || pc_out !== 8'hFE) begin n_err++; $display("FAIL wrap_rd got v=%b pcout=%h want 0/FE", id_valid, pc_out); end
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc[k] || id_pc_plus1 !== exp_p1[k] || id_inst !== mem[exp_pc[k]]) begin
        n_err++;
        $display("FAIL wrap%0d got pc=%h p1=%h want %h/%h", k, id_pc, id_pc_plus1, exp_pc[k], exp_p1[k]);
      end
    end
    n_vec++; if (pc_out !== 8'h01) begin n_err++; $display("FAIL wrap_pcout got %h want 01", pc_out); end
  endtask

  task automatic test_halt();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h1E;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    n_vec++; if (id_pc !== 8'h1F || id_valid !== 1'b1 || halted !== 1'b0 || pc_out !== 8'h20) begin n_err++; $display("FAIL halt_pre got pc=%h v=%b h=%b pcout=%h want 1F/1/0/20", id_pc, id_valid, halted, pc_out); end
    step();
`ifdef FETCH_HALT_DETECT_EN
    n_vec++; if (halted !== 1'b1 || id_valid !== 1'b0 || pc_out !== 8'h20) begin n_err++; $display("FAIL halt_enter got h=%b v=%b pcout=%h want 1/0/20", halted, id_valid, pc_out); end
    n_vec++; if (id_pc !== 8'h1F) begin n_err++; $display("FAIL halt_idpc got %h want 1F", id_pc); end
`else
    n_vec++; if (id_inst !== 16'h0000 || id_pc !== 8'h20 || id_valid !== 1'b1 || halted !== 1'b0) begin n_err++; $display("FAIL halt_word got inst=%h pc=%h v=%b h=%b want 0000/20/1/0", id_inst, id_pc, id_valid, halted); end
    n_vec++; if (pc_out !== 8'h21) begin n_err++; $display("FAIL halt_pcout got %h want 21", pc_out); end
`endif
    redirect_valid = 1'b1;
    redirect_pc = 8'h05;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    n_vec++; if (halted !== 1'b1 || id_valid !== 1'b0 || pc_out !== 8'h20) begin n_err++; $display("FAIL halt_ignore got h=%b v=%b pcout=%h want 1/0/20", halted, id_valid, pc_out); end
`else
    n_vec++; if (halted !== 1'b0 || id_valid !== 1'b0 || pc_out !== 8'h05) begin n_err++; $display("FAIL nohalt_rd got h=%b v=%b pcout=%h want 0/0/05", halted, id_valid, pc_out); end
`endif
  endtask

  task automatic test_async_reset();
    id_ready = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (pc_out !== 8'h00 || id_valid !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL arst_now got pc=%h v=%b h=%b want 00/0/0", pc_out, id_valid, halted); end
    n_vec++; if (id_inst !== 16'h0000 || id_pc !== 8'h00 || id_pc_plus1 !== 8'h00) begin n_err++; $display("FAIL arst_id got inst=%h pc=%h p1=%h want 0000/00/00", id_inst, id_pc, id_pc_plus1); end
    @(negedge clk);
    rst = 1'b0;
    step();
    n_vec++; if (id_valid !== 1'b0 || pc_out !== 8'h00) begin n_err++; $display("FAIL arst_boot got v=%b pc=%h want 0/00", id_valid, pc_out); end
    step();
    n_vec++; if (id_valid !== 1'b1 || id_pc !== 8'h00 || id_inst !== mem[0] || halted !== 1'b0) begin n_err++; $display("FAIL arst_restart got v=%b pc=%h inst=%h want 1/00/%h", id_valid, id_pc, id_inst, mem[0]); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = {8'hC5, 8'(i)};
    mem[8'h20] = 16'h0000;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    id_ready = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port pc_out, output, 8: fetch address to instruction memory (combinational-read memory, 16-bit words).
REQ-005 SHALL have port inst_in, input, 16: instruction word returned for pc_out in the same cycle.
REQ-006 SHALL have port redirect_valid, input, 1: branch/jump taken this cycle.
REQ-007 SHALL have port redirect_pc, input, 8: target PC, sampled when redirect_valid=1.
REQ-008 SHALL have port id_ready, input, 1: decode stage accepts id_* this cycle.
REQ-009 SHALL have port id_valid, output, 1: id_inst/id_pc/id_pc_plus1 hold a valid fetched instruction.
REQ-010 SHALL have port id_inst, output, 16: registered instruction to decode.
REQ-011 SHALL have port id_pc, output, 8: PC of id_inst.
REQ-012 SHALL have port id_pc_plus1, output, 8: id_pc+1 mod 256.
REQ-013 SHALL have port halted, output, 1: fetch stopped on halt word.

Function
REQ-014 SHALL implement states BOOT, RUN, HALT; pc_out SHALL equal the PC register at all times.
REQ-015 BOOT: one cycle after reset release, no capture, PC unchanged; then RUN unconditionally (covers memory image loading during reset).
REQ-016 RUN, slot free (id_valid=0 or id_ready=1), no redirect: capture inst_in, PC, PC+1 into id_*; id_valid<=1; PC<=PC+1.
REQ-017 RUN, stall (id_valid=1 and id_ready=0), no redirect: PC and all id_* outputs SHALL hold unchanged.
REQ-018 Redirect (redirect_valid=1) in BOOT or RUN SHALL take priority over capture and stall: PC<=redirect_pc, id_valid<=0, state RUN; the instruction at the old PC and any held id_* SHALL be discarded.
REQ-019 Redirect in HALT SHALL be ignored.
REQ-020 PC arithmetic SHALL be 8-bit modulo: 8'hFF increments to 8'h00; id_pc_plus1 wraps likewise.
REQ-021 A handshake completes when id_valid=1 and id_ready=1 at a rising edge; each captured instruction SHALL be presented to decode exactly once unless flushed by redirect.
REQ-022 id_inst/id_pc/id_pc_plus1 SHALL change only on capture; values while id_valid=0 are don't-care for decode but SHALL not be X after reset.
REQ-023 Throughput: one instruction per cycle with id_ready held 1; first id_valid=1 two edges after reset release.

Reset
REQ-024 rst=1 SHALL immediately force: PC=RESET_PC, state BOOT, id_valid=0, id_inst=16'h0000, id_pc=8'h00, id_pc_plus1=8'h00, halted=0.
REQ-025 rst asserted mid-stall, mid-redirect or in HALT SHALL discard all in-flight state and restart from REQ-015.

Configuration
REQ-026 Macro FETCH_HALT_DETECT_EN SHALL gate halt detection.
REQ-027 Defined: in RUN with slot free and no redirect, inst_in==16'h0000 SHALL NOT be captured; id_valid<=0, PC holds, state HALT, halted<=1; HALT exits only by reset.
REQ-028 Not defined: 16'h0000 SHALL be captured as an ordinary instruction; HALT unreachable; halted tied 0.

Verification
REQ-029 Reset release, id_ready=1, memory words 0..3 -> id_valid rises 2nd edge; id_pc sequence 00,01,02,03 with matching id_inst, one per cycle.
REQ-030 id_ready=0 for 3 cycles while id_pc=02 -> id_inst/id_pc/pc_out=03 frozen 3 cycles; after id_ready=1, id_pc 03 follows with no loss or duplicate.
REQ-031 redirect_valid=1, redirect_pc=8'h14 during a stall -> next edge id_valid=0, pc_out=14; next capture id_pc=14.
REQ-032 redirect_pc=8'hFE, id_ready=1 -> id_pc FE, FF, 00 with id_pc_plus1 FF, 00, 01.
REQ-033 FETCH_HALT_DETECT_EN defined, 16'h0000 at address 20 -> last id_pc=1F, then halted=1, id_valid=0, pc_out stays 20, redirect ignored; undefined build -> id_inst=0000 at id_pc=20, halted=0.
REQ-034 rst pulsed asynchronously between edges while in HALT -> outputs take REQ-024 values immediately; fetch restarts at RESET_PC.
